// File: rtl/htol_tx_if.sv
// rtl/htol_tx_if.sv - write-side and slow-side handshake bundle for htol_tx
interface htol_tx_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADD_WIDTH  = 4
);
  logic [DATA_WIDTH-1:0] din;
  logic                  wr_en;
  logic                  full;
  logic                  empty;
  logic [ADD_WIDTH:0]    count;
  logic                  ovf;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_req;
  logic                  rx_ack;
  logic                  busy;

  // transmitter side
  modport master (
    input  din, wr_en, rx_ack,
    output full, empty, count, ovf, tx_data, tx_req, busy
  );

  // producer / slow receiver side
  modport slave (
    output din, wr_en, rx_ack,
    input  full, empty, count, ovf, tx_data, tx_req, busy
  );
endinterface

// File: rtl/htol_tx.sv
// rtl/htol_tx.sv - fast-domain FIFO plus 4-phase req/ack transmitter
module htol_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int ADD_WIDTH  = 4
) (
  input  logic      wclk,
  input  logic      rst,
  htol_tx_if.master bus
);
  localparam int DEPTH = 1 << ADD_WIDTH;
  localparam logic [ADD_WIDTH:0] FULL_CNT = (ADD_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, REQ, RELEASE} state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADD_WIDTH-1:0]  wr_ptr, rd_ptr;
  logic [ADD_WIDTH:0]    count_q, count_next;
  logic                  full_q, empty_q, ovf_q;
  logic                  ack_s1, ack_s2;
  logic [1:0]            warm;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  tx_req_q, req_next;
  logic                  push, pop;

  // full is the registered pre-edge flag, so a pop in the same cycle never rescues a write
  assign push = bus.wr_en && !full_q;

  // occupancy update from this cycle's push/pop
  always_comb begin
    count_next = count_q;
    case ({push, pop})
      2'b10:   count_next = count_q + (ADD_WIDTH+1)'(1);
      2'b01:   count_next = count_q - (ADD_WIDTH+1)'(1);
      default: count_next = count_q;
    endcase
  end

  // FIFO storage; contents need no reset since pointers define validity
  always_ff @(posedge wclk) begin
    if (push) mem[wr_ptr] <= bus.din;
  end

  // pointers, registered occupancy flags and sticky overflow
  always_ff @(posedge wclk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADD_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + ADD_WIDTH'(1);
      count_q <= count_next;
      full_q  <= (count_next == FULL_CNT);
      empty_q <= (count_next == '0);
      if (bus.wr_en && full_q) ovf_q <= 1'b1;
    end
  end

  // ack synchroniser; warm keeps IDLE from trusting ack_s2 until two post-reset samples have landed
  always_ff @(posedge wclk) begin
    if (rst) begin
      ack_s1 <= 1'b0;
      ack_s2 <= 1'b0;
      warm   <= 2'b00;
    end else begin
      ack_s1 <= bus.rx_ack;
      ack_s2 <= ack_s1;
      warm   <= {warm[0], 1'b1};
    end
  end

  // handshake state, registered request and held output word
  always_ff @(posedge wclk) begin
    if (rst) begin
      state     <= IDLE;
      tx_req_q  <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state    <= state_next;
      tx_req_q <= req_next;
      if (pop) tx_data_q <= mem[rd_ptr];
    end
  end

  // next-state, request and pop decode
  always_comb begin
    state_next = state;
    req_next   = tx_req_q;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty_q && !ack_s2 && warm[1]) begin
          pop        = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        req_next   = 1'b1;
        state_next = REQ;
      end
      REQ: begin
        if (ack_s2) begin
          req_next   = 1'b0;
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        if (!ack_s2) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.full    = full_q;
  assign bus.empty   = empty_q;
  assign bus.count   = count_q;
  assign bus.ovf     = ovf_q;
  assign bus.tx_data = tx_data_q;
  assign bus.tx_req  = tx_req_q;
  assign bus.busy    = (state != IDLE);
endmodule

// File: tb/tb_htol_tx.sv
// tb/tb_htol_tx.sv - scoreboard bench for htol_tx with a slow-side receiver model
module tb_htol_tx;
  localparam int DW = 32;
  localparam int AW = 4;

  logic wclk = 1'b0;
  logic rst  = 1'b1;
  always #5 wclk = ~wclk;

  htol_tx_if #(.DATA_WIDTH(DW), .ADD_WIDTH(AW)) bus();

  logic rcv_ack   = 1'b0;
  logic stray_ack = 1'b0;
  bit   rcv_en    = 1'b0;
  int   rcv_fixed = -1;
  assign bus.rx_ack = rcv_ack | stray_ack;

  htol_tx #(.DATA_WIDTH(DW), .ADD_WIDTH(AW)) dut (
    .wclk(wclk),
    .rst (rst),
    .bus (bus.master)
  );

  logic [DW-1:0] exp_q[$];
  int  checks = 0;
  int  passes = 0;
  int  sent   = 0;
  int  rcvd   = 0;
  bit  rst_flag = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  task automatic wr(input logic [DW-1:0] d, input bit accept);
    bus.din   = d;
    bus.wr_en = 1'b1;
    if (accept) begin
      exp_q.push_back(d);
      sent++;
    end
    @(negedge wclk);
    bus.wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    rst_flag = 1'b1;
    exp_q.delete();
    @(negedge wclk);
    rst = 1'b0;
  endtask

  task automatic wait_req(input logic lvl, input int budget, input string name);
    int n = 0;
    while (bus.tx_req !== lvl && n < budget) begin
      @(negedge wclk);
      n++;
    end
    chk(name, bus.tx_req, lvl);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while ((bus.busy || rcvd != sent || !bus.empty) && n < budget) begin
      @(negedge wclk);
      n++;
    end
    chk(name, rcvd, sent);
    chk({name, "_busy"}, bus.busy, 1'b0);
  endtask

  // monitor: each rising tx_req delivers one word, which must be the oldest expected
  initial begin : monitor
    logic          prev_req;
    logic [DW-1:0] held;
    prev_req = 1'b0;
    held     = '0;
    forever begin
      @(negedge wclk);
      if (bus.tx_req && !prev_req) begin
        rcvd++;
        held     = bus.tx_data;
        rst_flag = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_word: got %0h expected none", bus.tx_data);
        end else begin
          chk("tx_data_order", bus.tx_data, exp_q.pop_front());
        end
      end else if (!bus.tx_req && prev_req && !rst_flag) begin
        chk("tx_data_stable", bus.tx_data, held);
      end
      prev_req = bus.tx_req;
    end
  end

  // slow receiver: raise ack some cycles after req, drop it some cycles after req falls
  initial begin : receiver
    forever begin
      @(negedge wclk);
      if (rcv_en && bus.tx_req && !rcv_ack) begin
        repeat (rcv_fixed >= 0 ? rcv_fixed : int'($urandom_range(0, 3))) @(negedge wclk);
        rcv_ack = 1'b1;
      end else if (rcv_en && !bus.tx_req && rcv_ack) begin
        repeat ($urandom_range(0, 3)) @(negedge wclk);
        rcv_ack = 1'b0;
      end else if (!rcv_en) begin
        rcv_ack = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bus.din   = '0;
    bus.wr_en = 1'b0;
    repeat (2) @(negedge wclk);
    do_reset();
    chk("rst_count",   bus.count,   0);
    chk("rst_empty",   bus.empty,   1'b1);
    chk("rst_full",    bus.full,    1'b0);
    chk("rst_ovf",     bus.ovf,     1'b0);
    chk("rst_tx_req",  bus.tx_req,  1'b0);
    chk("rst_busy",    bus.busy,    1'b0);
    chk("rst_tx_data", bus.tx_data, 0);
    repeat (3) @(negedge wclk);

    // single word latency
    rcv_fixed = 5;
    rcv_en    = 1'b1;
    wr(32'hA5A5_0001, 1'b1);
    chk("single_count_n", bus.count, 1);
    chk("single_busy_n",  bus.busy,  1'b0);
    @(negedge wclk);
    chk("single_data_n1", bus.tx_data, 32'hA5A5_0001);
    chk("single_req_n1",  bus.tx_req,  1'b0);
    chk("single_busy_n1", bus.busy,    1'b1);
    chk("single_count_n1", bus.count,  0);
    @(negedge wclk);
    chk("single_req_n2",  bus.tx_req,  1'b1);
    wait_drain(100, "single_drain");
    rcv_fixed = -1;

    // burst with ack blocked: one word goes into the handshake, sixteen fill the FIFO
    rcv_en = 1'b0;
    for (int i = 0; i < 17; i++) begin
      wr(DW'(i), 1'b1);
      if (i == 15) begin
        chk("burst_count_16w", bus.count, 15);
        chk("burst_full_16w",  bus.full,  1'b0);
      end
    end
    chk("burst_count_17w", bus.count, 16);
    chk("burst_full_17w",  bus.full,  1'b1);
    chk("burst_empty_17w", bus.empty, 1'b0);
    wr(32'hDEAD_BEEF, 1'b0);
    chk("ovf_set",   bus.ovf,   1'b1);
    chk("ovf_count", bus.count, 16);
    repeat (5) @(negedge wclk);
    chk("ovf_held",  bus.ovf,   1'b1);
    rcv_en = 1'b1;
    wait_drain(2000, "burst_drain");
    chk("burst_empty_end", bus.empty, 1'b1);
    chk("burst_count_end", bus.count, 0);
    chk("ovf_sticky",      bus.ovf,   1'b1);

    // reset in the middle of a handshake with ack held high
    rcv_en = 1'b0;
    wr(32'h1111_2222, 1'b1);
    wait_req(1'b1, 20, "mid_req_up");
    stray_ack = 1'b1;
    @(negedge wclk);
    do_reset();
    chk("mid_rst_req",   bus.tx_req,  1'b0);
    chk("mid_rst_count", bus.count,   0);
    chk("mid_rst_data",  bus.tx_data, 0);
    chk("mid_rst_busy",  bus.busy,    1'b0);
    chk("mid_rst_ovf",   bus.ovf,     1'b0);
    wr(32'h3333_4444, 1'b1);
    chk("mid_hold_req", bus.tx_req, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge wclk);
      chk("mid_hold_busy", bus.busy, 1'b0);
    end
    stray_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge wclk);
      chk("mid_ack_low_wait", bus.busy, 1'b0);
    end
    rcv_en = 1'b1;
    wait_req(1'b1, 10, "mid_req_after");
    wait_drain(100, "mid_drain");

    // stray ack while idle with one word queued
    stray_ack = 1'b1;
    repeat (2) @(negedge wclk);
    wr(32'h5A5A_0003, 1'b1);
    stray_ack = 1'b0;
    chk("stray_req",  bus.tx_req, 1'b0);
    chk("stray_busy", bus.busy,   1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge wclk);
      chk("stray_wait_busy", bus.busy, 1'b0);
    end
    wait_req(1'b1, 10, "stray_req_after");
    wait_drain(100, "stray_drain");

    // move pointers to slot 15 so the next load crosses the wrap
    for (int i = 0; i < 13; i++) wr($urandom, 1'b1);
    wait_drain(500, "fill_drain");

    // simultaneous write and pop at count 3
    stray_ack = 1'b1;
    repeat (2) @(negedge wclk);
    wr(32'hC0DE_0000, 1'b1);
    wr(32'hC0DE_0001, 1'b1);
    wr(32'hC0DE_0002, 1'b1);
    chk("simul_count_pre", bus.count, 3);
    stray_ack = 1'b0;
    repeat (2) @(negedge wclk);
    chk("simul_count_hold", bus.count, 3);
    chk("simul_busy_pre",   bus.busy,  1'b0);
    wr(32'hC0DE_0003, 1'b1);
    chk("simul_count", bus.count, 3);
    chk("simul_busy",  bus.busy,  1'b1);
    wait_drain(500, "simul_drain");

    // random traffic under random ack delays
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0 && (sent - rcvd) < 16) wr($urandom, 1'b1);
      else @(negedge wclk);
    end
    wait_drain(3000, "rand_drain");
    chk("final_empty", bus.empty, 1'b1);
    chk("final_count", bus.count, 0);
    chk("final_ovf",   bus.ovf,   1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
